// File: rtl/res_out_split.sv
// rtl/res_out_split.sv - splits a 2*W-bit result into two tagged W-bit bytes over a valid/ready channel.
module res_out_split #(
  parameter int W        = 8,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [2*W-1:0] res,
  input  logic           out_ready,
  input  logic           ovr_clr,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_half,
  output logic           busy,
  output logic           done,
  output logic           overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  // out_half value for the first byte: 0 = high half, 1 = low half
  localparam logic FIRST_HALF = HI_FIRST ? 1'b0 : 1'b1;

  state_t         state_q, state_d;
  logic [2*W-1:0] shadow_q, shadow_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           out_half_q, out_half_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           overrun_q, overrun_d;

  logic xfer;
  logic accept;
  logic dropped;

  assign xfer    = out_valid_q && out_ready;
  assign accept  = (state_q == IDLE) || ((state_q == SECOND) && xfer);
  assign dropped = load && !accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_half_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_half_q  <= out_half_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shadow_d = res;
          state_d  = FIRST;
        end
      end
      FIRST: begin
        if (xfer) state_d = SECOND;
      end
      SECOND: begin
        if (xfer) begin
          if (load) begin
            shadow_d = res;
            state_d  = FIRST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // a dropped load wins over a simultaneous clear
    if (dropped) overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  // Outputs are registered, so they are derived from the next state and next shadow.
  always_comb begin
    out_data_d  = '0;
    out_valid_d = 1'b0;
    out_half_d  = 1'b0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_q == SECOND) && xfer;
    case (state_d)
      FIRST: begin
        out_valid_d = 1'b1;
        out_half_d  = FIRST_HALF;
      end
      SECOND: begin
        out_valid_d = 1'b1;
        out_half_d  = ~FIRST_HALF;
      end
      default: ;
    endcase
    if (out_valid_d) begin
      out_data_d = out_half_d ? shadow_d[W-1:0] : shadow_d[2*W-1:W];
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_half  = out_half_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_res_out_split.sv
// tb/tb_res_out_split.sv - directed bench for res_out_split in both byte orders.
module tb_res_out_split;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] res = '0;
  logic        out_ready = 1'b0;
  logic        ovr_clr = 1'b0;

  logic [7:0] h_data, l_data;
  logic       h_valid, h_half, h_busy, h_done, h_ovr;
  logic       l_valid, l_half, l_busy, l_done, l_ovr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  res_out_split #(.W(8), .HI_FIRST(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .load(load), .res(res), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .out_data(h_data), .out_valid(h_valid), .out_half(h_half), .busy(h_busy),
    .done(h_done), .overrun(h_ovr)
  );

  res_out_split #(.W(8), .HI_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .load(load), .res(res), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .out_data(l_data), .out_valid(l_valid), .out_half(l_half), .busy(l_busy),
    .done(l_done), .overrun(l_ovr)
  );

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hi(input string name, input logic [7:0] d, input logic v, input logic h,
                        input logic b, input logic dn, input logic ov);
    checks++;
    if ({h_data, h_valid, h_half, h_busy, h_done, h_ovr} !== {d, v, h, b, dn, ov}) begin
      errors++;
      $display("FAIL %s: got data=%h valid=%b half=%b busy=%b done=%b ovr=%b, want data=%h valid=%b half=%b busy=%b done=%b ovr=%b",
               name, h_data, h_valid, h_half, h_busy, h_done, h_ovr, d, v, h, b, dn, ov);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    chk_hi("reset_init", 8'h00, 0, 0, 0, 0, 0);
    rst = 1'b0;
    load = 1'b1; res = 16'hA55A; out_ready = 1'b1;
    step();
    load = 1'b0;
    step();
    chk_hi("reset_pre_second", 8'h5A, 1, 1, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk_hi("reset_async", 8'h00, 0, 0, 0, 0, 0);
    checks++;
    if ({l_data, l_valid, l_half, l_busy, l_done, l_ovr} !== 13'h0) begin
      errors++;
      $display("FAIL reset_async_lo: got %h want 0", {l_data, l_valid, l_half, l_busy, l_done, l_ovr});
    end
    step();
    #2 rst = 1'b0;
    step();
    chk_hi("reset_after_release", 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic test_basic();
    load = 1'b1; res = 16'hA55A; out_ready = 1'b1;
    step();
    load = 1'b0;
    chk_hi("basic_c1", 8'hA5, 1, 0, 1, 0, 0);
    step();
    chk_hi("basic_c2", 8'h5A, 1, 1, 1, 0, 0);
    step();
    chk_hi("basic_c3", 8'h00, 0, 0, 0, 1, 0);
    step();
    chk_hi("basic_c4", 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    load = 1'b1; res = 16'hA55A; out_ready = 1'b0;
    step();
    load = 1'b0;
    chk_hi("bp_first", 8'hA5, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_hi("bp_hold", 8'hA5, 1, 0, 1, 0, 0);
    end
    out_ready = 1'b1;
    step();
    chk_hi("bp_second", 8'h5A, 1, 1, 1, 0, 0);
    step();
    chk_hi("bp_done", 8'h00, 0, 0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    load = 1'b1; res = 16'h1234; out_ready = 1'b1;
    step();
    load = 1'b0;
    chk_hi("b2b_12", 8'h12, 1, 0, 1, 0, 0);
    step();
    chk_hi("b2b_34", 8'h34, 1, 1, 1, 0, 0);
    load = 1'b1; res = 16'hBEEF;
    step();
    load = 1'b0;
    chk_hi("b2b_BE", 8'hBE, 1, 0, 1, 1, 0);
    step();
    chk_hi("b2b_EF", 8'hEF, 1, 1, 1, 0, 0);
    step();
    chk_hi("b2b_done", 8'h00, 0, 0, 0, 1, 0);
  endtask

  task automatic test_overrun();
    load = 1'b1; res = 16'hA55A; out_ready = 1'b0;
    step();
    chk_hi("ovr_first", 8'hA5, 1, 0, 1, 0, 0);
    res = 16'h0F0F;
    step();
    chk_hi("ovr_set", 8'hA5, 1, 0, 1, 0, 1);
    ovr_clr = 1'b1;
    step();
    chk_hi("ovr_set_beats_clr", 8'hA5, 1, 0, 1, 0, 1);
    load = 1'b0;
    step();
    chk_hi("ovr_clr", 8'hA5, 1, 0, 1, 0, 0);
    ovr_clr = 1'b0; out_ready = 1'b1;
    step();
    chk_hi("ovr_shadow_kept", 8'h5A, 1, 1, 1, 0, 0);
    step();
    chk_hi("ovr_done", 8'h00, 0, 0, 0, 1, 0);
  endtask

  task automatic test_lo_first();
    load = 1'b1; res = 16'h00FF; out_ready = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if ({l_data, l_valid, l_half} !== {8'hFF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL lo_first_byte: got data=%h valid=%b half=%b want FF 1 1", l_data, l_valid, l_half);
    end
    step();
    checks++;
    if ({l_data, l_valid, l_half} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lo_second_byte: got data=%h valid=%b half=%b want 00 1 0", l_data, l_valid, l_half);
    end
    step();
    checks++;
    if ({l_done, l_busy, l_valid} !== 3'b100) begin
      errors++;
      $display("FAIL lo_done: got done=%b busy=%b valid=%b want 1 0 0", l_done, l_busy, l_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_lo_first();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
